aes128_iter_core: RTL and testbench

- Iterative AES-128 encryption engine that reuses one round datapath across NR cycles.
- Built from the existing subbytes, shift_rows, Mix_Column, add_round_keys and keygen blocks.
- Adds what the combinational round lacks: registered state, on-the-fly round-key chaining, the initial AddRoundKey, a final round without MixColumns, and valid/ready handshakes on both sides.
- Sits between the host block-transfer interface and downstream ciphertext consumers.

---
 rtl/aes128_iter_core.sv | 172 +++++++++++++++++
 tb/tb_aes128_iter_core.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_iter_core.sv
// rtl/aes128_iter_core.sv - iterative AES-128 encryption core, one round per clock
module aes128_iter_core #(
    parameter int NR      = 10,
    parameter bit LAST_MC = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] pt,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ct,
    output logic         busy,
    output logic [3:0]   round_cnt
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [3:0] NR4 = 4'(NR);

    state_t       state;
    logic [127:0] state_reg;
    logic [127:0] key_reg;
    logic [127:0] kout;
    logic [127:0] round_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // S-box = affine map of the field inverse, computed as x^254 (maps 0 to 0)
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    // Byte i sits at row i%4, column i/4; row r rotates left by r columns
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Next round key from the previous one only; no full schedule is stored
    function automatic logic [127:0] keygen(input logic [3:0] rnd, input logic [127:0] k);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(k[23:16]) ^ rcon(rnd), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    always_comb begin
        logic [127:0] sr;
        kout = keygen(round_cnt, key_reg);
        sr   = shift_rows(sub_bytes(state_reg));
        if (round_cnt == NR4 && !LAST_MC) round_out = sr ^ kout;
        else                              round_out = mix_columns(sr) ^ kout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            state_reg <= '0;
            key_reg   <= '0;
            round_cnt <= '0;
            ct        <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state_reg <= pt ^ key;
                        key_reg   <= key;
                        round_cnt <= 4'd1;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                RUN: begin
                    state_reg <= round_out;
                    key_reg   <= kout;
                    if (round_cnt == NR4) begin
                        ct        <= round_out;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        round_cnt <= round_cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        round_cnt <= 4'd0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes128_iter_core.sv
// tb/tb_aes128_iter_core.sv - self-checking bench for aes128_iter_core
module tb_aes128_iter_core;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] pt = '0;
    logic [127:0] key = '0;

    logic         in_valid = 1'b0, out_ready = 1'b0;
    logic         in_ready, out_valid, busy;
    logic [127:0] ct;
    logic [3:0]   round_cnt;

    logic         mc_in_valid = 1'b0, mc_out_ready = 1'b0;
    logic         mc_in_ready, mc_out_valid, mc_busy;
    logic [127:0] mc_ct;
    logic [3:0]   mc_round_cnt;

    logic         n1_in_valid = 1'b0, n1_out_ready = 1'b0;
    logic         n1_in_ready, n1_out_valid, n1_busy;
    logic [127:0] n1_ct;
    logic [3:0]   n1_round_cnt;

    int checks = 0;
    int failures = 0;
    logic [127:0] exp_q [$];
    logic [7:0]   sb_tbl [256];

    aes128_iter_core #(.NR(10), .LAST_MC(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pt(pt), .key(key),
        .out_valid(out_valid), .out_ready(out_ready), .ct(ct), .busy(busy), .round_cnt(round_cnt));

    aes128_iter_core #(.NR(10), .LAST_MC(1'b1)) dut_mc (
        .clk(clk), .rst(rst), .in_valid(mc_in_valid), .in_ready(mc_in_ready), .pt(pt), .key(key),
        .out_valid(mc_out_valid), .out_ready(mc_out_ready), .ct(mc_ct), .busy(mc_busy),
        .round_cnt(mc_round_cnt));

    aes128_iter_core #(.NR(1), .LAST_MC(1'b0)) dut_n1 (
        .clk(clk), .rst(rst), .in_valid(n1_in_valid), .in_ready(n1_in_ready), .pt(pt), .key(key),
        .out_valid(n1_out_valid), .out_ready(n1_out_ready), .ct(n1_ct), .busy(n1_busy),
        .round_cnt(n1_round_cnt));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb_tbl[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb_tbl[0] = 8'h63;
    endtask

    function automatic logic [7:0] m2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] ref_aes(input logic [127:0] p_i, input logic [127:0] k_i,
                                              input int nr, input bit last_mc);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] k [16];
        logic [7:0] w [4];
        logic [7:0] rc, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            k[i] = k_i[127-8*i -: 8];
            s[i] = p_i[127-8*i -: 8] ^ k[i];
        end
        rc = 8'h01;
        for (int r = 1; r <= nr; r++) begin
            w[0] = sb_tbl[k[13]] ^ rc;
            w[1] = sb_tbl[k[14]];
            w[2] = sb_tbl[k[15]];
            w[3] = sb_tbl[k[12]];
            for (int i = 0; i < 16; i++) k[i] = k[i] ^ ((i < 4) ? w[i] : k[i-4]);
            rc = m2(rc);
            for (int i = 0; i < 16; i++) t[i] = sb_tbl[s[4*(((i/4) + (i%4)) % 4) + (i%4)]];
            if (r != nr || last_mc) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3;
                    t[4*c+3] = m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = t[i] ^ k[i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Called at a falling edge; returns one falling edge after the accept edge
    task automatic send_block(input logic [127:0] p, input logic [127:0] k, output bit ok);
        int n;
        n = 0;
        pt = p;
        key = k;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        if (ok) exp_q.push_back(ref_aes(p, k, 10, 1'b0));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (ct !== 128'h0) begin failures++; $display("FAIL reset_ct got=%h exp=0", ct); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (round_cnt !== 4'd0) begin failures++; $display("FAIL reset_round_cnt got=%0d exp=0", round_cnt); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_first_edge_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_fips_c1();
        bit ok;
        int n;
        logic [127:0] e;
        out_ready = 1'b1;
        send_block(C1_PT, C1_KEY, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL c1_accept got=%b exp=1", ok); end
        wait_out(n);
        checks++; if (n + 1 !== 11) begin failures++; $display("FAIL c1_latency got=%0d exp=11", n + 1); end
        checks++; if (ct !== C1_CT) begin failures++; $display("FAIL c1_ct got=%h exp=%h", ct, C1_CT); end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if (ct !== e) begin failures++; $display("FAIL c1_model got=%h exp=%h", ct, e); end
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL c1_drop_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_fips_b();
        bit ok;
        int n;
        logic [127:0] e;
        out_ready = 1'b1;
        send_block(B_PT, B_KEY, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL b_accept got=%b exp=1", ok); end
        n = 0;
        while (!out_valid && n < 40) begin
            checks++;
            if (round_cnt !== 4'(n + 1)) begin
                failures++;
                $display("FAIL b_round_cnt got=%0d exp=%0d", round_cnt, n + 1);
            end
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 10) begin failures++; $display("FAIL b_round_steps got=%0d exp=10", n); end
        checks++; if (round_cnt !== 4'd10) begin failures++; $display("FAIL b_done_round_cnt got=%0d exp=10", round_cnt); end
        checks++; if (ct !== B_CT) begin failures++; $display("FAIL b_ct got=%h exp=%h", ct, B_CT); end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if (ct !== e) begin failures++; $display("FAIL b_model got=%h exp=%h", ct, e); end
        end
        @(negedge clk);
        checks++; if (round_cnt !== 4'd0) begin failures++; $display("FAIL b_idle_round_cnt got=%0d exp=0", round_cnt); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int n;
        int bad;
        logic [127:0] e;
        out_ready = 1'b0;
        send_block(C1_PT, C1_KEY, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_accept got=%b exp=1", ok); end
        wait_out(n);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid got=%b exp=1", out_valid); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : C1_CT;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i >= 5 && i < 8) begin
                pt = 128'hdeadbeef_00000000_cafef00d_12345678 ^ 128'(i);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (ct !== e || in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL bp_hold bad_cycles=%0d exp=0 ct=%h exp_ct=%h", bad, ct, e);
        end
        pt = B_PT;
        key = B_KEY;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_release_busy got=%b exp=0", busy); end
        exp_q.push_back(ref_aes(B_PT, B_KEY, 10, 1'b0));
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(n);
        checks++; if (n + 1 !== 11) begin failures++; $display("FAIL bp_b2b_latency got=%0d exp=11", n + 1); end
        checks++; if (ct !== B_CT) begin failures++; $display("FAIL bp_b2b_ct got=%h exp=%h", ct, B_CT); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc, first, second, got;
        logic [127:0] e;
        out_ready = 1'b1;
        pt = C1_PT;
        key = C1_KEY;
        in_valid = 1'b1;
        first = -1;
        second = -1;
        got = 0;
        cyc = 0;
        while (got < 2 && cyc < 100) begin
            if (out_valid) begin
                got++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                checks++; if (ct !== e) begin failures++; $display("FAIL b2b_ct got=%h exp=%h", ct, e); end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_aes(pt, key, 10, 1'b0));
                if (first < 0) begin
                    first = cyc;
                end else begin
                    second = cyc;
                end
            end
            @(negedge clk);
            cyc++;
            if (first >= 0) begin pt = B_PT; key = B_KEY; end
            if (second >= 0) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        checks++; if (got !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", got); end
        checks++; if (second - first !== 12) begin failures++; $display("FAIL b2b_period got=%0d exp=12", second - first); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int n;
        logic [127:0] e;
        out_ready = 1'b1;
        send_block(C1_PT, C1_KEY, ok);
        exp_q.delete();
        n = 0;
        while (round_cnt != 4'd5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (round_cnt !== 4'd5) begin failures++; $display("FAIL mid_reach5 got=%0d exp=5", round_cnt); end
        rst = 1'b1;
        #1;
        checks++; if (round_cnt !== 4'd0) begin failures++; $display("FAIL mid_round_cnt got=%0d exp=0", round_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
        checks++; if (ct !== 128'h0) begin failures++; $display("FAIL mid_ct got=%h exp=0", ct); end
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL mid_handshake got=%b%b exp=00", out_valid, in_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_block(C1_PT, C1_KEY, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL mid_rerun_accept got=%b exp=1", ok); end
        wait_out(n);
        checks++; if (n + 1 !== 11) begin failures++; $display("FAIL mid_rerun_latency got=%0d exp=11", n + 1); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : C1_CT;
        checks++; if (ct !== e) begin failures++; $display("FAIL mid_rerun_ct got=%h exp=%h", ct, e); end
        @(negedge clk);
    endtask

    task automatic test_last_mc();
        int n;
        logic [127:0] e;
        mc_out_ready = 1'b1;
        pt = C1_PT;
        key = C1_KEY;
        mc_in_valid = 1'b1;
        n = 0;
        while (!mc_in_ready && n < 20) begin @(negedge clk); n++; end
        checks++; if (mc_in_ready !== 1'b1) begin failures++; $display("FAIL mc_in_ready got=%b exp=1", mc_in_ready); end
        exp_q.push_back(ref_aes(C1_PT, C1_KEY, 10, 1'b1));
        @(negedge clk);
        mc_in_valid = 1'b0;
        n = 0;
        while (!mc_out_valid && n < 40) begin @(negedge clk); n++; end
        checks++; if (n + 1 !== 11) begin failures++; $display("FAIL mc_latency got=%0d exp=11", n + 1); end
        e = exp_q.pop_front();
        checks++; if (mc_ct !== e) begin failures++; $display("FAIL mc_ct got=%h exp=%h", mc_ct, e); end
        @(negedge clk);
        checks++; if (mc_busy !== 1'b0 || mc_round_cnt !== 4'd0) begin
            failures++; $display("FAIL mc_idle got=%b/%0d exp=0/0", mc_busy, mc_round_cnt);
        end
    endtask

    task automatic test_nr1();
        int n;
        logic [127:0] e;
        n1_out_ready = 1'b1;
        pt = B_PT;
        key = B_KEY;
        n1_in_valid = 1'b1;
        n = 0;
        while (!n1_in_ready && n < 20) begin @(negedge clk); n++; end
        checks++; if (n1_in_ready !== 1'b1) begin failures++; $display("FAIL nr1_in_ready got=%b exp=1", n1_in_ready); end
        exp_q.push_back(ref_aes(B_PT, B_KEY, 1, 1'b0));
        @(negedge clk);
        n1_in_valid = 1'b0;
        n = 0;
        while (!n1_out_valid && n < 40) begin @(negedge clk); n++; end
        checks++; if (n + 1 !== 2) begin failures++; $display("FAIL nr1_latency got=%0d exp=2", n + 1); end
        checks++; if (n1_round_cnt !== 4'd1) begin failures++; $display("FAIL nr1_round_cnt got=%0d exp=1", n1_round_cnt); end
        e = exp_q.pop_front();
        checks++; if (n1_ct !== e) begin failures++; $display("FAIL nr1_ct got=%h exp=%h", n1_ct, e); end
        @(negedge clk);
        checks++; if (n1_busy !== 1'b0) begin failures++; $display("FAIL nr1_idle_busy got=%b exp=0", n1_busy); end
    endtask

    task automatic test_streaming();
        int received;
        int drv_timeouts;
        exp_q.delete();
        received = 0;
        drv_timeouts = 0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    int n;
                    in_valid = 1'b0;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    pt = {$urandom, $urandom, $urandom, $urandom};
                    key = {$urandom, $urandom, $urandom, $urandom};
                    in_valid = 1'b1;
                    n = 0;
                    while (!in_ready && n < 200) begin @(negedge clk); n++; end
                    if (!in_ready) begin
                        drv_timeouts++;
                        break;
                    end
                    exp_q.push_back(ref_aes(pt, key, 10, 1'b0));
                    @(negedge clk);
                end
                in_valid = 1'b0;
            end
            begin
                int cyc;
                logic r;
                logic [127:0] e;
                cyc = 0;
                while (received < 100 && cyc < 6000) begin
                    r = 1'($urandom_range(0, 1));
                    out_ready = r;
                    if (out_valid && r) begin
                        received++;
                        checks++;
                        if (exp_q.size() == 0) begin
                            failures++;
                            $display("FAIL stream_extra got=%h exp=none", ct);
                        end else begin
                            e = exp_q.pop_front();
                            if (ct !== e) begin
                                failures++;
                                $display("FAIL stream_ct idx=%0d got=%h exp=%h", received, ct, e);
                            end
                        end
                    end
                    @(negedge clk);
                    cyc++;
                end
                out_ready = 1'b0;
            end
        join
        checks++; if (drv_timeouts !== 0) begin failures++; $display("FAIL stream_accept_timeout got=%0d exp=0", drv_timeouts); end
        checks++; if (received !== 100) begin failures++; $display("FAIL stream_count got=%0d exp=100", received); end
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL stream_leftover got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips_c1();
        test_fips_b();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_last_mc();
        test_nr1();
        test_streaming();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
